// File: rtl/data_bus_arbiter_pkg.sv
// Shared constants and types for the two-master data-bus arbiter.
package data_bus_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [BE_W-1:0] BE_WORD  = 4'b1111;
  localparam logic            OWNER_M0 = 1'b0;
  localparam logic            OWNER_M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } busState_t;

  typedef struct packed {
    logic              write;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } busTxn_t;

endpackage

// File: rtl/bus_rr_arbiter.sv
// Two-way grant decision with last-owner memory (round-robin) and an
// M1 starvation counter used when M0 has fixed priority.
module bus_rr_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter bit          FAIR         = 1'b1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iArb,
  input  logic iM0Req,
  input  logic iM1Req,
  output logic oWinM1_c
);

  localparam int unsigned CNT_W = 4;

  logic             lastOwner;
  logic [CNT_W-1:0] starveCnt;
  logic             conflictWinM1;

  // Only a real conflict consults the policy; a lone requester always wins.
  always_comb begin
    conflictWinM1 = 1'b0;
    if (FAIR) conflictWinM1 = (lastOwner == OWNER_M0);
    else      conflictWinM1 = (starveCnt == CNT_W'(STARVE_LIMIT));
    oWinM1_c = iM1Req & (~iM0Req | conflictWinM1);
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      lastOwner <= OWNER_M1;
      starveCnt <= '0;
    end else if (iArb && (iM0Req || iM1Req)) begin
      lastOwner <= oWinM1_c ? OWNER_M1 : OWNER_M0;
      if (oWinM1_c)
        starveCnt <= '0;
      else if (iM1Req && (starveCnt != CNT_W'(STARVE_LIMIT)))
        starveCnt <= starveCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Serialises core (M0) and DMA/loader (M1) accesses onto the single
// data-memory slave port, one transaction in flight.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned RD_LATENCY   = 2,
  parameter bit          FAIR         = 1'b1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iM0ReadEnable,
  input  logic        iM0WriteEnable,
  input  logic [3:0]  iM0ByteEnable,
  input  logic [31:0] iM0Address,
  input  logic [31:0] iM0WriteData,
  output logic [31:0] oM0ReadData,
  output logic        oM0Wait,
  input  logic        iM1Req,
  input  logic        iM1Write,
  input  logic [3:0]  iM1ByteEnable,
  input  logic [31:0] iM1Address,
  input  logic [31:0] iM1WriteData,
  output logic        oM1Gnt,
  output logic [31:0] oM1ReadData,
  output logic        oM1RdValid,
  output logic        oSReadEnable,
  output logic        oSWriteEnable,
  output logic [3:0]  oSByteEnable,
  output logic [31:0] oSAddress,
  output logic [31:0] oSWriteData,
  input  logic [31:0] iSReadData
);

  localparam int unsigned LAT_W = 3;

  busState_t        state, stateNext;
  busTxn_t          txn, winTxn;
  logic             txnOwner;
  logic [LAT_W-1:0] latCnt;
  logic             m0Req, anyReq, arbNow, winM1;

  assign m0Req  = iM0ReadEnable | iM0WriteEnable;
  assign anyReq = m0Req | iM1Req;
  assign arbNow = (state == ST_IDLE);

  bus_rr_arbiter #(
    .FAIR         (FAIR),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) uArb (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iArb     (arbNow),
    .iM0Req   (m0Req),
    .iM1Req   (iM1Req),
    .oWinM1_c (winM1)
  );

  // Both M0 enables high resolves to a write.
  always_comb begin
    winTxn = '{write: iM0WriteEnable, be: iM0ByteEnable,
               addr: iM0Address, data: iM0WriteData};
    if (winM1)
      winTxn = '{write: iM1Write, be: iM1ByteEnable,
                 addr: iM1Address, data: iM1WriteData};
  end

  always_comb begin
    stateNext     = state;
    oM1Gnt        = 1'b0;
    oM1RdValid    = 1'b0;
    oSReadEnable  = 1'b0;
    oSWriteEnable = 1'b0;
    oSByteEnable  = '0;
    oSAddress     = '0;
    oSWriteData   = '0;
    // Handshake outputs are forced low while reset is held.
    oM0Wait = iRST & m0Req & !((state == ST_DONE) && (txnOwner == OWNER_M0));
    case (state)
      ST_IDLE: begin
        oM1Gnt = iRST & winM1;
        if (anyReq) stateNext = ST_ISSUE;
      end
      ST_ISSUE: begin
        oSReadEnable  = ~txn.write;
        oSWriteEnable = txn.write;
        oSByteEnable  = txn.be;
        oSAddress     = txn.addr;
        oSWriteData   = txn.data;
        stateNext     = txn.write ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (latCnt == '0) stateNext = ST_DONE;
      end
      ST_DONE: begin
        oM1RdValid = (txnOwner == OWNER_M1) & ~txn.write;
        stateNext  = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state       <= ST_IDLE;
      txn         <= '0;
      txnOwner    <= OWNER_M0;
      latCnt      <= '0;
      oM0ReadData <= '0;
      oM1ReadData <= '0;
    end else begin
      state <= stateNext;
      if (arbNow && anyReq) begin
        txn      <= winTxn;
        txnOwner <= winM1 ? OWNER_M1 : OWNER_M0;
      end
      // Read data lands on the last WAIT cycle, RD_LATENCY after the strobe.
      if (state == ST_ISSUE) begin
        latCnt <= LAT_W'(RD_LATENCY - 1);
      end else if (state == ST_WAIT) begin
        if (latCnt != '0)
          latCnt <= latCnt - LAT_W'(1);
        else if (txnOwner == OWNER_M0)
          oM0ReadData <= iSReadData;
        else
          oM1ReadData <= iSReadData;
      end
    end
  end

endmodule
